// File: rtl/column_drop_if.sv
// column_drop_if: key requests in, cursor/turn/drop-strobe/fill status out
interface column_drop_if #(parameter int COLS = 7);
    logic                    key_drop;
    logic                    key_left;
    logic                    key_right;
    logic [$clog2(COLS)-1:0] cursor;
    logic [1:0]              token;
    logic [COLS-1:0]         drop;
    logic [COLS-1:0]         col_full;
    logic                    busy;
    modport master (
        output key_drop, key_left, key_right,
        input  cursor, token, drop, col_full, busy
    );
    modport slave (
        input  key_drop, key_left, key_right,
        output cursor, token, drop, col_full, busy
    );
endinterface

// File: rtl/column_drop_ctrl.sv
// column_drop_ctrl: Connect Four turn/cursor/drop controller; CURSOR_WRAP_EN makes the cursor wrap at the edges
module column_drop_ctrl #(
    parameter int COLS        = 7,
    parameter int ROWS        = 6,
    parameter int FALL_CYCLES = ROWS + 1
) (
    input logic         clock,
    input logic         reset,
    column_drop_if.slave bus
);
    localparam int CW = $clog2(COLS);
    localparam int FW = $clog2(ROWS + 1);
    localparam int NW = $clog2(FALL_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DROP, SETTLE} state_t;
    state_t          state;
    logic            prev_drop, prev_left, prev_right;
    logic            ev_drop, ev_left, ev_right;
    logic [CW-1:0]   cursor;
    logic [1:0]      token;
    logic [COLS-1:0] drop, col_full;
    logic            busy;
    logic [FW-1:0]   fill [COLS];
    logic [NW-1:0]   cnt;
    assign ev_drop      = bus.key_drop & ~prev_drop;
    assign ev_left      = bus.key_left & ~prev_left;
    assign ev_right     = bus.key_right & ~prev_right;
    assign bus.cursor   = cursor;
    assign bus.token    = token;
    assign bus.drop     = drop;
    assign bus.col_full = col_full;
    assign bus.busy     = busy;
    // key edge detection, cursor movement and the IDLE/DROP/SETTLE turn sequence
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            prev_drop  <= 1'b0;
            prev_left  <= 1'b0;
            prev_right <= 1'b0;
            cursor     <= '0;
            token      <= 2'b01;
            drop       <= '0;
            col_full   <= '0;
            busy       <= 1'b0;
            cnt        <= '0;
            for (int c = 0; c < COLS; c++) fill[c] <= '0;
        end else begin
            prev_drop  <= bus.key_drop;
            prev_left  <= bus.key_left;
            prev_right <= bus.key_right;
            case (state)
                IDLE: begin
                    if (ev_drop) begin
                        if (!col_full[cursor]) begin
                            state <= DROP;
                            drop  <= {{(COLS-1){1'b0}}, 1'b1} << cursor;
                            busy  <= 1'b1;
                        end
                    end else if (ev_left && !ev_right) begin
`ifdef CURSOR_WRAP_EN
                        cursor <= (cursor == '0) ? CW'(COLS - 1) : cursor - CW'(1);
`else
                        cursor <= (cursor == '0) ? cursor : cursor - CW'(1);
`endif
                    end else if (ev_right && !ev_left) begin
`ifdef CURSOR_WRAP_EN
                        cursor <= (cursor == CW'(COLS - 1)) ? '0 : cursor + CW'(1);
`else
                        cursor <= (cursor == CW'(COLS - 1)) ? cursor : cursor + CW'(1);
`endif
                    end
                end
                DROP: begin
                    drop  <= '0;
                    state <= SETTLE;
                    cnt   <= NW'(FALL_CYCLES - 1);
                    if (fill[cursor] != FW'(ROWS)) fill[cursor] <= fill[cursor] + FW'(1);
                    col_full[cursor] <= (fill[cursor] >= FW'(ROWS - 1));
                end
                SETTLE: begin
                    cnt <= cnt - NW'(1);
                    if (cnt <= NW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        token <= ~token;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
